// File: rtl/ap_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ap_isa_pkg
// Brief   : Shared ISA constants and cache state encodings for the AP front end.
// Revision: 1.0
// ============================================================================
package ap_isa_pkg;

  localparam int c_ISA_DEPTH      = 64;
  localparam int c_ISA_DEPTH_LOG2 = $clog2(c_ISA_DEPTH);
  localparam int c_INS_WIDTH      = 64;
  localparam int c_INS_BYTES      = c_INS_WIDTH / 8;

  // SENT_INS must stay 3: program_counter compares against it
  localparam logic [3:0] c_ST_IDLE      = 4'd0;
  localparam logic [3:0] c_ST_LOAD_REQ  = 4'd1;
  localparam logic [3:0] c_ST_LOAD_DATA = 4'd2;
  localparam logic [3:0] c_ST_SENT_INS  = 4'd3;
  localparam logic [3:0] c_ST_END       = 4'd4;

endpackage
`default_nettype wire

// File: rtl/ins_cache_fill_if.sv
`default_nettype none
// ============================================================================
// Module  : ins_cache_fill_if
// Brief   : Program-counter side and DDR burst-read signals of the ins cache.
// Revision: 1.0
// ============================================================================
interface ins_cache_fill_if #(
  parameter int ADDR_WIDTH_MEM = 16,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int INS_WIDTH      = 64
);
  logic [ADDR_WIDTH_MEM-1:0] addr_ins;
  logic                      ins_cache_rdy;
  logic [3:0]                st_cur_ins_cache;
  logic [9:0]                load_times;
  logic [INS_WIDTH-1:0]      instruction;
  logic                      ddr_rd_req;
  logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr;
  logic                      ddr_rd_ack;
  logic [INS_WIDTH-1:0]      ddr_rd_data;
  logic                      ddr_rd_data_valid;

  modport slave (
    input  addr_ins, ddr_rd_ack, ddr_rd_data, ddr_rd_data_valid,
    output ins_cache_rdy, st_cur_ins_cache, load_times, instruction,
           ddr_rd_req, ddr_rd_addr
  );

  modport master (
    output addr_ins, ddr_rd_ack, ddr_rd_data, ddr_rd_data_valid,
    input  ins_cache_rdy, st_cur_ins_cache, load_times, instruction,
           ddr_rd_req, ddr_rd_addr
  );
endinterface
`default_nettype wire

// File: rtl/ins_cache_mem.sv
`default_nettype none
// ============================================================================
// Module  : ins_cache_mem
// Brief   : Simple dual-port RAM, synchronous write and registered read.
// Revision: 1.0
// ============================================================================
module ins_cache_mem #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             we,
  input  wire logic [AW-1:0]    waddr,
  input  wire logic [WIDTH-1:0] wdata,
  input  wire logic             re,
  input  wire logic [AW-1:0]    raddr,
  output logic      [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Read register holds its value unless re, so it doubles as the output hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    r_rdata <= '0;
    else if (re) r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/ins_cache_fill.sv
`default_nettype none
// ============================================================================
// Module  : ins_cache_fill
// Brief   : One-window instruction cache refilled from DDR in ISA_DEPTH bursts.
// Revision: 1.0
// ============================================================================
module ins_cache_fill
  import ap_isa_pkg::*;
#(
  parameter int ADDR_WIDTH_MEM  = 16,
  parameter int ISA_DEPTH       = c_ISA_DEPTH,
  parameter int TOTAL_ISA_DEPTH = 128,
  parameter int DDR_ADDR_WIDTH  = 28,
  parameter int INS_WIDTH       = c_INS_WIDTH,
  parameter int ISA_BASE_ADDR   = 0
) (
  input  wire logic        clk,
  input  wire logic        rst,
  ins_cache_fill_if.slave  cif
);

  localparam int c_OFS_W = $clog2(ISA_DEPTH);
  localparam int c_BYTES = INS_WIDTH / 8;
  localparam logic [ADDR_WIDTH_MEM-1:0] c_TOTAL       = ADDR_WIDTH_MEM'(TOTAL_ISA_DEPTH);
  localparam logic [DDR_ADDR_WIDTH-1:0] c_CHUNK_BYTES = DDR_ADDR_WIDTH'(ISA_DEPTH * c_BYTES);
  localparam logic [DDR_ADDR_WIDTH-1:0] c_BASE        = DDR_ADDR_WIDTH'(ISA_BASE_ADDR);
  localparam logic [c_OFS_W-1:0]        c_LAST_PTR    = c_OFS_W'(ISA_DEPTH - 1);

  logic [3:0]                r_state;
  logic [3:0]                w_state_nxt;
  logic [9:0]                r_chunk;
  logic [c_OFS_W-1:0]        r_wptr;
  logic [9:0]                r_load_times;
  logic                      r_rdy;
  logic                      r_req;
  logic [DDR_ADDR_WIDTH-1:0] r_ddr_addr;

  logic                      w_jump;
  logic                      w_past_end;
  logic [9:0]                w_addr_chunk;
  logic                      w_hit;
  logic                      w_last_beat;
  logic                      w_mem_we;
  logic                      w_mem_re;
  logic                      w_miss;
  logic                      w_fill_done;
  logic                      w_ack_take;

  assign w_jump       = cif.addr_ins[ADDR_WIDTH_MEM-1];
  assign w_past_end   = (cif.addr_ins >= c_TOTAL);
  assign w_addr_chunk = 10'(cif.addr_ins >> c_OFS_W);
  assign w_hit        = (w_addr_chunk == (r_load_times - 10'd1));
  assign w_last_beat  = cif.ddr_rd_data_valid && (r_wptr == c_LAST_PTR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:      w_state_nxt = c_ST_LOAD_REQ;
      c_ST_LOAD_REQ:  if (cif.ddr_rd_ack) w_state_nxt = c_ST_LOAD_DATA;
      c_ST_LOAD_DATA: if (w_last_beat)    w_state_nxt = c_ST_SENT_INS;
      c_ST_SENT_INS: begin
        if (w_jump)          w_state_nxt = c_ST_SENT_INS;
        else if (w_past_end) w_state_nxt = c_ST_END;
        else if (!w_hit)     w_state_nxt = c_ST_LOAD_REQ;
      end
      c_ST_END:       if (!w_jump && !w_past_end) w_state_nxt = c_ST_SENT_INS;
      default:        w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_re    = 1'b0;
    w_miss      = 1'b0;
    w_fill_done = 1'b0;
    w_ack_take  = 1'b0;
    case (r_state)
      c_ST_LOAD_REQ:  w_ack_take = cif.ddr_rd_ack;
      c_ST_LOAD_DATA: begin
        w_mem_we    = cif.ddr_rd_data_valid;
        w_fill_done = w_last_beat;
      end
      c_ST_SENT_INS: begin
        w_mem_re = !w_jump && !w_past_end && w_hit;
        w_miss   = !w_jump && !w_past_end && !w_hit;
      end
      default: ;
    endcase
  end

  // rdy and req are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_chunk      <= '0;
      r_wptr       <= '0;
      r_load_times <= '0;
      r_rdy        <= 1'b0;
      r_req        <= 1'b0;
      r_ddr_addr   <= '0;
    end else begin
      r_rdy <= (w_state_nxt == c_ST_SENT_INS) || (w_state_nxt == c_ST_END);
      r_req <= (w_state_nxt == c_ST_LOAD_REQ);
      if (r_state == c_ST_IDLE) begin
        r_chunk    <= '0;
        r_ddr_addr <= c_BASE;
      end else if (w_miss) begin
        r_chunk    <= w_addr_chunk;
        r_ddr_addr <= c_BASE + DDR_ADDR_WIDTH'(w_addr_chunk) * c_CHUNK_BYTES;
      end
      if (w_ack_take)                   r_wptr <= '0;
      else if (w_mem_we && !w_last_beat) r_wptr <= r_wptr + 1'b1;
      if (w_fill_done) r_load_times <= r_chunk + 10'd1;
    end
  end

  ins_cache_mem #(
    .DEPTH (ISA_DEPTH),
    .WIDTH (INS_WIDTH),
    .AW    (c_OFS_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (w_mem_we),
    .waddr (r_wptr),
    .wdata (cif.ddr_rd_data),
    .re    (w_mem_re),
    .raddr (cif.addr_ins[c_OFS_W-1:0]),
    .rdata (cif.instruction)
  );

  assign cif.ins_cache_rdy    = r_rdy;
  assign cif.st_cur_ins_cache = r_state;
  assign cif.load_times       = r_load_times;
  assign cif.ddr_rd_req       = r_req;
  assign cif.ddr_rd_addr      = r_ddr_addr;

endmodule
`default_nettype wire

// File: tb/tb_ins_cache_fill.sv
`default_nettype none
// ============================================================================
// Module  : tb_ins_cache_fill
// Brief   : Directed self-checking bench with a DDR burst model and scoreboard.
// Revision: 1.0
// ============================================================================
module tb_ins_cache_fill;
  import ap_isa_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ins_cache_fill_if #(.ADDR_WIDTH_MEM(16), .DDR_ADDR_WIDTH(28), .INS_WIDTH(64)) cif ();

  ins_cache_fill #(
    .ADDR_WIDTH_MEM  (16),
    .ISA_DEPTH       (64),
    .TOTAL_ISA_DEPTH (128),
    .DDR_ADDR_WIDTH  (28),
    .INS_WIDTH       (64),
    .ISA_BASE_ADDR   (0)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .cif (cif)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [63:0] sb_q[$];

  function automatic logic [63:0] word(input int i);
    logic [15:0] v;
    v = 16'(i);
    return {16'hA5C3, v, ~v, 16'(i * 7 + 3)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [63:0] exp;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      exp = sb_q.pop_front();
      chk(tag, cif.instruction, exp);
    end
  endtask

  task automatic read_hit(input int a);
    cif.addr_ins = 16'(a);
    sb_q.push_back(word(a));
    tick();
    sb_check("hit_data");
  endtask

  task automatic chk_reset_vals();
    chk("rst_state", 64'(cif.st_cur_ins_cache), 64'(c_ST_IDLE));
    chk("rst_rdy",   64'(cif.ins_cache_rdy), 64'd0);
    chk("rst_lt",    64'(cif.load_times), 64'd0);
    chk("rst_ins",   cif.instruction, 64'd0);
    chk("rst_req",   64'(cif.ddr_rd_req), 64'd0);
    chk("rst_addr",  64'(cif.ddr_rd_addr), 64'd0);
  endtask

  // DDR side: accept one request after ack_dly cycles, then stream 64 beats
  task automatic fill(input int exp_addr, input int ack_dly, input bit gapped,
                      input int chunk, input int old_lt);
    int waited;
    waited = 0;
    while (cif.ddr_rd_req !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    chk("req_seen", 64'(cif.ddr_rd_req), 64'd1);
    if (cif.ddr_rd_req !== 1'b1) return;
    chk("req_addr", 64'(cif.ddr_rd_addr), 64'(exp_addr));
    chk("req_rdy_low", 64'(cif.ins_cache_rdy), 64'd0);
    repeat (ack_dly) tick();
    chk("req_hold", 64'(cif.ddr_rd_req), 64'd1);
    chk("req_addr_hold", 64'(cif.ddr_rd_addr), 64'(exp_addr));
    cif.ddr_rd_ack = 1'b1;
    tick();
    cif.ddr_rd_ack = 1'b0;
    chk("req_drop", 64'(cif.ddr_rd_req), 64'd0);
    chk("st_load_data", 64'(cif.st_cur_ins_cache), 64'(c_ST_LOAD_DATA));
    for (int k = 0; k < 64; k++) begin
      if (gapped) begin
        cif.ddr_rd_data_valid = 1'b0;
        cif.ddr_rd_data       = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
      end
      cif.ddr_rd_data_valid = 1'b1;
      cif.ddr_rd_data       = word(chunk * 64 + k);
      if (k == 63) chk("lt_before_last", 64'(cif.load_times), 64'(old_lt));
      tick();
    end
    cif.ddr_rd_data_valid = 1'b0;
    chk("fill_lt",  64'(cif.load_times), 64'(chunk + 1));
    chk("fill_st",  64'(cif.st_cur_ins_cache), 64'(c_ST_SENT_INS));
    chk("fill_rdy", 64'(cif.ins_cache_rdy), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cif.addr_ins          = 16'd0;
    cif.ddr_rd_ack        = 1'b0;
    cif.ddr_rd_data       = 64'd0;
    cif.ddr_rd_data_valid = 1'b0;
    tick();
    tick();
    chk_reset_vals();
    rst = 1'b1;

    // Cold fill of chunk 0
    fill(0, 3, 1'b0, 0, 0);
    read_hit(0);
    read_hit(37);

    // Sequential boundary into chunk 1
    read_hit(63);
    cif.addr_ins = 16'd64;
    tick();
    chk("miss_rdy_fall", 64'(cif.ins_cache_rdy), 64'd0);
    fill(512, 2, 1'b0, 1, 1);
    chk("ins_hold_refill", cif.instruction, word(63));
    read_hit(64);
    read_hit(127);

    // Jump address (MSB set) holds everything
    cif.addr_ins = 16'h8000;
    repeat (5) begin
      tick();
      chk("jump_st",  64'(cif.st_cur_ins_cache), 64'(c_ST_SENT_INS));
      chk("jump_ins", cif.instruction, word(127));
      chk("jump_req", 64'(cif.ddr_rd_req), 64'd0);
    end

    // Back-jump into chunk 0: load_times decreases
    cif.addr_ins = 16'd5;
    tick();
    chk("back_rdy_fall", 64'(cif.ins_cache_rdy), 64'd0);
    fill(0, 1, 1'b0, 0, 2);
    read_hit(5);

    // End of program and return
    cif.addr_ins = 16'd128;
    tick();
    chk("end_st",  64'(cif.st_cur_ins_cache), 64'(c_ST_END));
    chk("end_rdy", 64'(cif.ins_cache_rdy), 64'd1);
    tick();
    chk("end_st2", 64'(cif.st_cur_ins_cache), 64'(c_ST_END));
    chk("end_req", 64'(cif.ddr_rd_req), 64'd0);
    chk("end_ins", cif.instruction, word(5));
    cif.addr_ins = 16'd10;
    tick();
    chk("end_ret_st", 64'(cif.st_cur_ins_cache), 64'(c_ST_SENT_INS));
    chk("end_ret_rdy", 64'(cif.ins_cache_rdy), 64'd1);
    read_hit(10);

    // Reset part-way through a chunk 1 burst
    cif.addr_ins = 16'd64;
    tick();
    chk("mid_req", 64'(cif.ddr_rd_req), 64'd1);
    chk("mid_addr", 64'(cif.ddr_rd_addr), 64'd512);
    cif.ddr_rd_ack = 1'b1;
    tick();
    cif.ddr_rd_ack = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cif.ddr_rd_data_valid = 1'b1;
      cif.ddr_rd_data       = word(64 + k);
      tick();
    end
    cif.ddr_rd_data_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk_reset_vals();
    tick();
    tick();
    chk_reset_vals();
    cif.addr_ins = 16'd0;
    rst = 1'b1;

    // Refill chunk 0 with gapped beats, then read every word back
    fill(0, 0, 1'b1, 0, 0);
    for (int k = 0; k < 64; k++) read_hit(k);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
